esm_issue_buffer: RTL and testbench

//  bs-entry holding buffer that feeds ESM_core_IIM: publishes per-entry ready vector (ready_index),

---
 rtl/esm_pkg.sv | 19 +
 rtl/esm_free_slot_finder.sv | 24 ++
 rtl/esm_issue_buffer.sv | 155 +++++++++++++++
 tb/tb_esm_issue_buffer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared definitions for the ESM issue buffer: index width helper,
// output-stage state encodings and statistics counter width.
package esm_pkg;

    // Index width needed to address n entries.
    function automatic int IDX_W(input int n);
        return $clog2(n);
    endfunction

    // Output stage: EMPTY has nothing to present, HELD presents out_data.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } out_state_t;

    localparam int          STAT_W   = 32;
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/esm_free_slot_finder.sv
// Priority encoder over the free-slot vector: returns the lowest free index
// and a flag telling whether any slot is free at all.
module esm_free_slot_finder
    import esm_pkg::*;
#(
    parameter int bs = 16,
    localparam int IW = IDX_W(bs)
) (
    input  logic [bs-1:0] free_vec,
    output logic [IW-1:0] idx,
    output logic          any_free
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        idx      = '0;
        any_free = |free_vec;
        for (int i = bs - 1; i >= 0; i--) begin
            if (free_vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/esm_issue_buffer.sv
// bs-entry holding buffer in front of ESM_core_IIM. Entries are allocated
// into the lowest free slot, woken, picked by the core via buffer_index and
// issued through a one-deep output stage.
// Optional feature: define ESM_ISSUE_STATS_EN to add stat_issued/stat_miss.
module esm_issue_buffer
    import esm_pkg::*;
#(
    parameter int bs = 16,
    parameter int DW = 32,
    localparam int IW = IDX_W(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_rdy_now,
    input  logic          wake_valid,
    input  logic [IW-1:0] wake_idx,
    output logic [bs-1:0] ready_index,
    output logic          esm_start,
    input  logic [IW-1:0] buffer_index,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic [IW:0]   count
`ifdef ESM_ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0] stat_miss
`endif
);

    logic [bs-1:0] valid_q;
    logic [bs-1:0] ready_q;
    logic [DW-1:0] payload_q [bs];
    out_state_t    state_q;
    out_state_t    state_d;

    logic [bs-1:0] free_vec;
    logic [IW-1:0] alloc_idx;
    logic          any_free;
    logic          alloc;
    logic          issue;
    logic          out_slot_free;
    logic          sel_ready;

    // Free slots come from registered valid bits only: a slot issued this
    // cycle becomes allocatable next cycle, never in the same one.
    assign free_vec = ~valid_q;

    esm_free_slot_finder #(.bs(bs)) u_free_slot_finder (
        .free_vec (free_vec),
        .idx      (alloc_idx),
        .any_free (any_free)
    );

    // in_ready comes from the registered count, so a full buffer stays full
    // during the cycle that issues an entry.
    assign in_ready      = (count < (IW + 1)'(bs));
    assign alloc         = in_valid & in_ready & any_free;
    assign ready_index   = valid_q & ready_q;
    assign out_slot_free = (state_q == S_EMPTY) | out_ready;
    assign sel_ready     = ready_index[buffer_index];
    assign issue         = out_slot_free & sel_ready;
    assign esm_start     = (|ready_index) & out_slot_free;
    assign out_valid     = (state_q == S_HELD);

    // Entry bookkeeping: wake first, then issue clears, then allocation sets;
    // later assignments win, so a wake on an issued slot has no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            if (wake_valid && valid_q[wake_idx]) ready_q[wake_idx] <= 1'b1;
            if (issue) begin
                valid_q[buffer_index] <= 1'b0;
                ready_q[buffer_index] <= 1'b0;
            end
            if (alloc) begin
                valid_q[alloc_idx] <= 1'b1;
                ready_q[alloc_idx] <= in_rdy_now;
            end
        end
    end

    // Payload storage written on allocation.
    // NOTE: the payload array has no reset; valid_q guards every read, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (alloc) payload_q[alloc_idx] <= in_data;
    end

    // Occupancy counter: alloc and issue in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({alloc, issue})
                2'b10:   count <= count + (IW + 1)'(1);
                2'b01:   count <= count - (IW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // Output-stage next state: issue always lands in HELD; HELD drains when accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (issue) state_d = S_HELD;
            S_HELD: begin
                if (issue)          state_d = S_HELD;
                else if (out_ready) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Output data register: loads only on issue, otherwise holds stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_idx  <= '0;
        end else if (issue) begin
            out_data <= payload_q[buffer_index];
            out_idx  <= buffer_index;
        end
    end

`ifdef ESM_ISSUE_STATS_EN
    logic miss;
    assign miss = out_slot_free & (|ready_index) & ~sel_ready;

    // Saturating issue and stale-selection counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= '0;
            stat_miss   <= '0;
        end else begin
            if (issue && stat_issued != STAT_MAX) stat_issued <= stat_issued + 1'b1;
            if (miss && stat_miss != STAT_MAX)    stat_miss   <= stat_miss + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Self-checking bench for esm_issue_buffer: an entry-level model plus
// directed scenarios with hand-computed expectations.
module tb_esm_issue_buffer;
    import esm_pkg::*;

    localparam int bs = 16;
    localparam int DW = 32;
    localparam int IW = IDX_W(bs);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_rdy_now;
    logic          wake_valid;
    logic [IW-1:0] wake_idx;
    logic [bs-1:0] ready_index;
    logic          esm_start;
    logic [IW-1:0] buffer_index;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic [IW:0]   count;
`ifdef ESM_ISSUE_STATS_EN
    logic [31:0]   stat_issued;
    logic [31:0]   stat_miss;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    esm_issue_buffer #(.bs(bs), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_rdy_now   (in_rdy_now),
        .wake_valid   (wake_valid),
        .wake_idx     (wake_idx),
        .ready_index  (ready_index),
        .esm_start    (esm_start),
        .buffer_index (buffer_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .count        (count)
`ifdef ESM_ISSUE_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_miss    (stat_miss)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_valid [bs];
    bit            m_ready [bs];
    logic [DW-1:0] m_data  [bs];
    bit            m_held;
    logic [DW-1:0] m_od;
    int            m_oi;
    longint        m_issued;
    longint        m_miss;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < bs; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic logic [bs-1:0] m_rdy_vec();
        logic [bs-1:0] v = '0;
        for (int i = 0; i < bs; i++) v[i] = m_valid[i] && m_ready[i];
        return v;
    endfunction

    function automatic bit m_slot_free();
        return !m_held || out_ready;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [bs-1:0] rv;
        bit            sf;
        bit            iss;
        bit            do_alloc;
        int            fs;
        if (rst) begin
            for (int i = 0; i < bs; i++) begin
                m_valid[i] = 0;
                m_ready[i] = 0;
            end
            m_held   = 0;
            m_od     = '0;
            m_oi     = 0;
            m_issued = 0;
            m_miss   = 0;
        end else begin
            rv       = m_rdy_vec();
            sf       = m_slot_free();
            iss      = sf && rv[buffer_index];
            do_alloc = in_valid && (m_count() < bs);
            fs       = -1;
            for (int i = bs - 1; i >= 0; i--) if (!m_valid[i]) fs = i;
            if (sf && rv != '0 && !rv[buffer_index]) m_miss++;
            if (wake_valid && m_valid[wake_idx]) m_ready[wake_idx] = 1;
            if (iss) begin
                m_od  = m_data[buffer_index];
                m_oi  = int'(buffer_index);
                m_held = 1;
                m_valid[buffer_index] = 0;
                m_ready[buffer_index] = 0;
                m_issued++;
            end else if (m_held && out_ready) begin
                m_held = 0;
            end
            if (do_alloc && fs >= 0) begin
                m_valid[fs] = 1;
                m_ready[fs] = in_rdy_now;
                m_data[fs]  = in_data;
            end
        end
    end

    // Compare every output against the model each cycle, away from the edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready_index", 64'(ready_index), 64'(m_rdy_vec()));
            check("in_ready",    64'(in_ready),    64'(m_count() < bs));
            check("count",       64'(count),       64'(m_count()));
            check("esm_start",   64'(esm_start),   64'((m_rdy_vec() != '0) && m_slot_free()));
            check("out_valid",   64'(out_valid),   64'(m_held));
            check("out_data",    64'(out_data),    64'(m_od));
            check("out_idx",     64'(out_idx),     64'(m_oi));
`ifdef ESM_ISSUE_STATS_EN
            check("stat_issued", 64'(stat_issued), 64'(m_issued));
            check("stat_miss",   64'(stat_miss),   64'(m_miss));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] BASE_A = 32'hA000_0000;
    localparam logic [DW-1:0] BASE_B = 32'hB000_0000;

    initial begin
`ifdef ESM_ISSUE_STATS_EN
        logic [31:0] miss0;
`endif
        rst = 1; in_valid = 0; in_data = '0; in_rdy_now = 0;
        wake_valid = 0; wake_idx = '0; buffer_index = '0; out_ready = 0;
        tick();
        tick();
        cmp_en = 1;
        check("reset count", 64'(count), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        rst = 0;
        tick();

        // 1: reset mid-traffic
        in_valid = 1; in_rdy_now = 1;
        for (int k = 0; k < 4; k++) begin
            in_data = BASE_A + DW'(k);
            tick();
        end
        in_valid = 0;
        buffer_index = 4'd0;
        tick();
        check("t1 out_valid before rst", 64'(out_valid), 64'd1);
        check("t1 count before rst", 64'(count), 64'd3);
        rst = 1;
        tick();
        check("t1 ready_index", 64'(ready_index), 64'd0);
        check("t1 count", 64'(count), 64'd0);
        check("t1 out_valid", 64'(out_valid), 64'd0);
        rst = 0;
        tick();

        // 2: fill all 16 entries not ready, then a dropped 17th request
        in_valid = 1; in_rdy_now = 0;
        for (int k = 0; k < bs; k++) begin
            in_data = BASE_B + DW'(k);
            tick();
        end
        check("t2 count full", 64'(count), 64'd16);
        check("t2 in_ready full", 64'(in_ready), 64'd0);
        in_data = 32'hDEAD_BEEF;
        tick();
        in_valid = 0;
        check("t2 count after 17th", 64'(count), 64'd16);
        check("t2 ready_index", 64'(ready_index), 64'd0);

        // 3: wake 5 and issue it
        wake_valid = 1; wake_idx = 4'd5;
        tick();
        wake_valid = 0;
        check("t3 ready_index", 64'(ready_index), 64'h0020);
        buffer_index = 4'd5; out_ready = 1;
        #1;
        check("t3 esm_start", 64'(esm_start), 64'd1);
        tick();
        out_ready = 0;
        check("t3 out_valid", 64'(out_valid), 64'd1);
        check("t3 out_idx", 64'(out_idx), 64'd5);
        check("t3 out_data", 64'(out_data), 64'(BASE_B + 32'd5));
        check("t3 count", 64'(count), 64'd15);

        // 4: back-pressure with ready entries present
        wake_valid = 1; wake_idx = 4'd1;
        tick();
        wake_idx = 4'd2;
        tick();
        wake_valid = 0;
        buffer_index = 4'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4 out_data stable", 64'(out_data), 64'(BASE_B + 32'd5));
            check("t4 count", 64'(count), 64'd15);
            check("t4 ready_index", 64'(ready_index), 64'h0006);
        end
        out_ready = 1;
        tick();
        check("t4 out_idx", 64'(out_idx), 64'd1);
        check("t4 out_data", 64'(out_data), 64'(BASE_B + 32'd1));
        check("t4 count after", 64'(count), 64'd14);

        // 5: stale choice pointing at a non-ready entry
`ifdef ESM_ISSUE_STATS_EN
        miss0 = stat_miss;
`endif
        buffer_index = 4'd3;
        tick();
        check("t5 out_valid", 64'(out_valid), 64'd0);
        check("t5 count", 64'(count), 64'd14);
        check("t5 ready_index", 64'(ready_index), 64'h0004);
`ifdef ESM_ISSUE_STATS_EN
        check("t5 stat_miss", 64'(stat_miss), 64'(miss0 + 32'd1));
`endif

        // 6: issue from a full buffer while allocation is requested
        in_valid = 1; in_rdy_now = 0;
        in_data = 32'hC000_0001;
        tick();
        in_data = 32'hC000_0005;
        tick();
        in_valid = 0;
        check("t6 count full", 64'(count), 64'd16);
        wake_valid = 1; wake_idx = 4'd7;
        tick();
        wake_valid = 0;
        buffer_index = 4'd7; in_valid = 1; in_data = 32'hC0DE_0007;
        #1;
        check("t6 in_ready in issue cycle", 64'(in_ready), 64'd0);
        tick();
        check("t6 out_idx", 64'(out_idx), 64'd7);
        check("t6 count after issue", 64'(count), 64'd15);
        check("t6 in_ready after issue", 64'(in_ready), 64'd1);
        buffer_index = 4'd0;
        tick();
        in_valid = 0;
        check("t6 count refilled", 64'(count), 64'd16);
        check("t6 ready_index", 64'(ready_index), 64'h0004);
        wake_valid = 1; wake_idx = 4'd7; buffer_index = 4'd7;
        tick();
        wake_valid = 0;
        tick();
        check("t6 refilled slot idx", 64'(out_idx), 64'd7);
        check("t6 refilled slot data", 64'(out_data), 64'h0000_0000_C0DE_0007);
        check("t6 count final", 64'(count), 64'd15);

        // Wake on a now-invalid slot is ignored.
        wake_valid = 1; wake_idx = 4'd7;
        tick();
        wake_valid = 0;
        check("wake invalid", 64'(ready_index), 64'h0004);
        tick();

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
